// File: rtl/onehot_scan_decoder_pkg.sv
// Shared definitions for the one-hot scan decoder family: mode encodings
// and the one-hot expansion helper used by the decoder top level.
package onehot_scan_decoder_pkg;

  // Operating modes selected by the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // Widest one-hot vector the helper can produce; callers truncate to their width.
  localparam int unsigned MAX_OUT_W = 256;

  // Returns a vector with only bit 'idx' set.
  function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx);
    logic [MAX_OUT_W-1:0] one;
    one = {{(MAX_OUT_W-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_prescaler.sv
// Scan-rate prescaler: produces a one-cycle tick every SCAN_DIV enabled
// cycles. clr restarts the interval, run low freezes the count.
module scan_prescaler #(
  parameter int SCAN_DIV = 4,
  parameter int DIV_W    = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] divCnt_q;
  logic [DIV_W-1:0] divCnt_d;

  // A clear cycle never ticks, so every restart yields a full SCAN_DIV interval.
  always_comb begin
    tick_o   = run_i && !clr_i && (divCnt_q == DIV_LAST);
    divCnt_d = divCnt_q;
    if (clr_i) begin
      divCnt_d = '0;
    end else if (run_i) begin
      if (tick_o) begin
        divCnt_d = '0;
      end else begin
        divCnt_d = divCnt_q + DIV_W'(1);
      end
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      divCnt_q <= '0;
    end else begin
      divCnt_q <= divCnt_d;
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable, plus autonomous
// scan-up / scan-down modes that step the active line at a prescaled
// rate and pulse wrap_o whenever the index rolls over.
module onehot_scan_decoder
  import onehot_scan_decoder_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 4,
  parameter int DIV_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [1:0]            mode_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [(2**SEL_W)-1:0] out_o,
  output logic [SEL_W-1:0]      idx_o,
  output logic                  wrap_o
);

  localparam int OUT_W = 2 ** SEL_W;

  mode_e             mode;
  mode_e             modePrev_q;
  logic              enPrev_q;
  logic [SEL_W-1:0]  idx_q;
  logic [SEL_W-1:0]  idx_d;
  logic [OUT_W-1:0]  out_q;
  logic [OUT_W-1:0]  out_d;
  logic              wrap_q;
  logic              wrap_d;
  logic              scanRun;
  logic              scanClr;
  logic              stepTick;

  assign mode = mode_e'(mode_i);

  // The scan interval restarts on a mode change, while disabled, and on the
  // first enabled edge after a disable, so re-enabling shows the old index
  // for a full SCAN_DIV cycles just like a mode switch does.
  always_comb begin
    scanRun = en_i && ((mode == MODE_UP) || (mode == MODE_DOWN));
    scanClr = !en_i || (mode != modePrev_q) || !enPrev_q;
  end

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .run_i  (scanRun),
    .clr_i  (scanClr),
    .tick_o (stepTick)
  );

  // Next index, one-hot output and wrap flag; idx arithmetic wraps modulo OUT_W naturally.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    unique case (mode)
      MODE_DIRECT: idx_d = sel_i;
      MODE_UP: begin
        if (stepTick) begin
          idx_d  = idx_q + SEL_W'(1);
          wrap_d = (idx_q == {SEL_W{1'b1}});
        end
      end
      MODE_DOWN: begin
        if (stepTick) begin
          idx_d  = idx_q - SEL_W'(1);
          wrap_d = (idx_q == {SEL_W{1'b0}});
        end
      end
      MODE_HOLD: idx_d = idx_q;
      default:   idx_d = idx_q;
    endcase
    out_d = en_i ? OUT_W'(onehot(32'(idx_d))) : '0;
  end

  // Output, index and mode/enable history registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q      <= '0;
      out_q      <= '0;
      wrap_q     <= 1'b0;
      modePrev_q <= MODE_DIRECT;
      enPrev_q   <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      out_q      <= out_d;
      wrap_q     <= wrap_d;
      modePrev_q <= mode;
      enPrev_q   <= en_i;
    end
  end

  assign out_o  = out_q;
  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed testbench for onehot_scan_decoder (SEL_W=2, SCAN_DIV=4) with a
// second SCAN_DIV=1 instance sharing the same stimulus.
module tb_onehot_scan_decoder;

  logic       clk;
  logic       rstN;
  logic       en;
  logic [1:0] mode;
  logic [1:0] sel;
  logic [3:0] out4;
  logic [1:0] idx4;
  logic       wrap4;
  logic [3:0] out1;
  logic [1:0] idx1;
  logic       wrap1;

  int compared   = 0;
  int mismatched = 0;

  onehot_scan_decoder #(.SEL_W(2), .SCAN_DIV(4), .DIV_W(16)) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .en_i   (en),
    .mode_i (mode),
    .sel_i  (sel),
    .out_o  (out4),
    .idx_o  (idx4),
    .wrap_o (wrap4)
  );

  onehot_scan_decoder #(.SEL_W(2), .SCAN_DIV(1), .DIV_W(4)) dutDiv1 (
    .clk_i  (clk),
    .rst_ni (rstN),
    .en_i   (en),
    .mode_i (mode),
    .sel_i  (sel),
    .out_o  (out1),
    .idx_o  (idx1),
    .wrap_o (wrap1)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Reset values while held, then first registered value after release.
  task automatic test_reset();
    rstN = 1'b0; en = 1'b1; mode = 2'b00; sel = 2'd2;
    stepClock(); stepClock();
    compared++;
    if (out4 !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_out got %b want %b", out4, 4'b0000); end
    compared++;
    if (idx4 !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_idx got %0d want %0d", idx4, 0); end
    compared++;
    if (wrap4 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wrap got %b want %b", wrap4, 1'b0); end
    rstN = 1'b1;
    stepClock();
    compared++;
    if (out4 !== 4'b0100) begin mismatched++; $display("[TB] FAIL release_out got %b want %b", out4, 4'b0100); end
    compared++;
    if (idx4 !== 2'd2) begin mismatched++; $display("[TB] FAIL release_idx got %0d want %0d", idx4, 2); end
  endtask

  // Direct mode sweep of every select, then disable with sel=3.
  task automatic test_direct();
    logic [3:0] expOut [0:3];
    expOut = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    en = 1'b1; mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      stepClock();
      compared++;
      if (out4 !== expOut[i]) begin mismatched++; $display("[TB] FAIL direct_out sel=%0d got %b want %b", i, out4, expOut[i]); end
      compared++;
      if (idx4 !== 2'(i)) begin mismatched++; $display("[TB] FAIL direct_idx sel=%0d got %0d want %0d", i, idx4, i); end
    end
    en = 1'b0; sel = 2'd3;
    stepClock();
    compared++;
    if (out4 !== 4'b0000) begin mismatched++; $display("[TB] FAIL disabled_out got %b want %b", out4, 4'b0000); end
    compared++;
    if (idx4 !== 2'd3) begin mismatched++; $display("[TB] FAIL disabled_idx got %0d want %0d", idx4, 3); end
  endtask

  // Scan-up from idx 2: 0100 x4, 1000 x4, then 0001 with a wrap pulse.
  task automatic test_scan_up();
    logic [3:0] expOut [0:9];
    logic       expWrap [0:9];
    expOut  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100,
                4'b1000, 4'b1000, 4'b1000, 4'b1000,
                4'b0001, 4'b0001};
    expWrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    en = 1'b1; mode = 2'b00; sel = 2'd2;
    stepClock();
    mode = 2'b01;
    for (int i = 0; i < 10; i++) begin
      stepClock();
      compared++;
      if (out4 !== expOut[i]) begin mismatched++; $display("[TB] FAIL scan_up_out edge=%0d got %b want %b", i, out4, expOut[i]); end
      compared++;
      if (wrap4 !== expWrap[i]) begin mismatched++; $display("[TB] FAIL scan_up_wrap edge=%0d got %b want %b", i, wrap4, expWrap[i]); end
    end
  endtask

  // Scan-down from idx 1 through the 0 -> 3 wrap, then freeze in hold.
  task automatic test_scan_down();
    logic [3:0] expOut [0:13];
    logic       expWrap [0:13];
    expOut  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                4'b0001, 4'b0001, 4'b0001, 4'b0001,
                4'b1000, 4'b1000, 4'b1000, 4'b1000,
                4'b0100, 4'b0100};
    expWrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    en = 1'b1; mode = 2'b00; sel = 2'd1;
    stepClock();
    mode = 2'b10;
    for (int i = 0; i < 14; i++) begin
      stepClock();
      compared++;
      if (out4 !== expOut[i]) begin mismatched++; $display("[TB] FAIL scan_down_out edge=%0d got %b want %b", i, out4, expOut[i]); end
      compared++;
      if (wrap4 !== expWrap[i]) begin mismatched++; $display("[TB] FAIL scan_down_wrap edge=%0d got %b want %b", i, wrap4, expWrap[i]); end
    end
    mode = 2'b11;
    for (int i = 0; i < 10; i++) begin
      stepClock();
      compared++;
      if (out4 !== 4'b0100 || wrap4 !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL hold_frozen edge=%0d got out=%b wrap=%b want out=%b wrap=%b", i, out4, wrap4, 4'b0100, 1'b0);
      end
    end
  endtask

  // Disable for 3 cycles mid scan-up, then an up -> down switch; both restart the interval.
  task automatic test_restart();
    logic [3:0] expRe [0:4];
    logic [3:0] expSw [0:4];
    expRe = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    expSw = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    en = 1'b1; mode = 2'b00; sel = 2'd0;
    stepClock();
    mode = 2'b01;
    stepClock(); stepClock();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepClock();
      compared++;
      if (out4 !== 4'b0000 || idx4 !== 2'd0 || wrap4 !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL disable_scan edge=%0d got out=%b idx=%0d wrap=%b want out=%b idx=%0d wrap=%b", i, out4, idx4, wrap4, 4'b0000, 0, 1'b0);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepClock();
      compared++;
      if (out4 !== expRe[i]) begin mismatched++; $display("[TB] FAIL reenable_out edge=%0d got %b want %b", i, out4, expRe[i]); end
    end
    stepClock();
    mode = 2'b10;
    for (int i = 0; i < 5; i++) begin
      stepClock();
      compared++;
      if (out4 !== expSw[i] || wrap4 !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL mode_switch edge=%0d got out=%b wrap=%b want out=%b wrap=%b", i, out4, wrap4, expSw[i], 1'b0);
      end
    end
  endtask

  // Asynchronous reset between edges at idx=3, div=2 clears outputs without a clock.
  task automatic test_async_reset();
    en = 1'b1; mode = 2'b00; sel = 2'd2;
    stepClock();
    mode = 2'b01;
    for (int i = 0; i < 7; i++) stepClock();
    compared++;
    if (out4 !== 4'b1000 || idx4 !== 2'd3) begin
      mismatched++;
      $display("[TB] FAIL pre_reset got out=%b idx=%0d want out=%b idx=%0d", out4, idx4, 4'b1000, 3);
    end
    #2;
    rstN = 1'b0;
    #1;
    compared++;
    if (out4 !== 4'b0000 || idx4 !== 2'd0 || wrap4 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset got out=%b idx=%0d wrap=%b want out=%b idx=%0d wrap=%b", out4, idx4, wrap4, 4'b0000, 0, 1'b0);
    end
    stepClock();
    rstN = 1'b1;
  endtask

  // SCAN_DIV=1 instance steps every cycle and wraps every 4th step.
  task automatic test_scan_div1();
    logic [1:0] expIdx;
    logic [3:0] expOut;
    logic       expWrap;
    en = 1'b1; mode = 2'b00; sel = 2'd0;
    stepClock();
    compared++;
    if (out1 !== 4'b0001) begin mismatched++; $display("[TB] FAIL div1_start got %b want %b", out1, 4'b0001); end
    mode = 2'b01;
    for (int k = 0; k < 9; k++) begin
      stepClock();
      expIdx  = 2'(k % 4);
      expOut  = 4'(1 << (k % 4));
      expWrap = (k > 0) && (k % 4 == 0);
      compared++;
      if (idx1 !== expIdx || out1 !== expOut || wrap1 !== expWrap) begin
        mismatched++;
        $display("[TB] FAIL div1_scan edge=%0d got idx=%0d out=%b wrap=%b want idx=%0d out=%b wrap=%b", k, idx1, out1, wrap1, expIdx, expOut, expWrap);
      end
    end
  endtask

  // Test sequence.
  initial begin
    rstN = 1'b0; en = 1'b0; mode = 2'b00; sel = 2'd0;
    #1;
    test_reset();
    test_direct();
    test_scan_up();
    test_scan_down();
    test_restart();
    test_async_reset();
    test_scan_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
